sdp_ram_burst_reader: RTL and testbench
=======================================

// Module: sdp_ram_burst_reader
// PURPOSE
//   Read-port master for blockRAMx32SDP (LOW_LATENCY, 1-cycle read). Given a start address and word
//   count, issues rden/rdaddrs, captures rddata exactly one cycle after each rden, and presents the words
//   as a valid/ready stream through a 2-entry buffer, so downstream stalls never drop data. Sits between
//   the SDP RAM read port and any consumer (e.g. result unloading).
// PARAMETERS
//   ADDRS_WIDTH  11  RAM address width; must match the RAM instance
//   LEN_WIDTH    12  burst length width; must hold 2**ADDRS_WIDTH
// PORTS
//   CLK          in   1            clock, all state on rising edge
//   RESET_N      in   1            asynchronous, active-low reset
//   start        in   1            begin burst; sampled only in IDLE
//   start_addrs  in   ADDRS_WIDTH  first word address
//   length       in   LEN_WIDTH    words to read; 0 allowed
//   busy         out  1            high from accepted start until done
//   done         out  1            1-cycle pulse, burst complete
//   rden         out  1            RAM read enable
//   rdaddrs      out  ADDRS_WIDTH  RAM read address
//   rddata       in   32           RAM read data, valid the cycle after rden
//   m_valid      out  1            stream word available
//   m_ready      in   1            consumer accepts word when m_valid & m_ready
//   m_data       out  32           stream word
//   m_last       out  1            m_data is final word of burst
// BEHAVIOUR
//   - Reset (async on RESET_N low, mid-burst included): state IDLE; busy, done, rden, m_valid, m_last = 0;
//     rdaddrs, m_data = 0; buffer emptied, inflight cleared, remaining count cleared. No RAM read after release.
//   - FSM IDLE -> READ on start with length != 0: latch addr=start_addrs, remaining=length, busy=1 next cycle.
//     IDLE with start & length==0: no reads, done=1 next cycle, busy stays 0. start while busy is ignored.
//   - READ: rden=1 when remaining != 0 and (count + inflight - pop) < 2, where count = buffer occupancy
//     (0..2), inflight = rden issued last cycle (0/1), pop = m_valid & m_ready. On rden: rdaddrs=addr,
//     addr <= addr+1 mod 2**ADDRS_WIDTH (wrap 2**ADDRS_WIDTH-1 -> 0), remaining <= remaining-1.
//     READ -> DRAIN when the last read issues.
//   - Capture: in the cycle after rden, rddata is pushed into the buffer at that clock edge. rddata is
//     never sampled at any other time (RAM output changes on write-port activity).
//   - Buffer: 2-entry FIFO, m_data/m_valid from head register. Push and pop in same cycle are both legal
//     (count unchanged). Credit rule guarantees no push to a full buffer; overflow is a design error.
//   - m_last=1 with the head word when it is word number `length` of the burst; 0 otherwise.
//   - DRAIN -> IDLE on pop of the m_last word; done=1 the following cycle; busy=0 same cycle as done.
//   - Latency: start sampled at edge 0 -> rden high cycle 1 -> rddata cycle 2 -> m_valid high cycle 3.
//   - Throughput: 1 word/cycle with m_ready held high; m_ready low stalls reads after 2 words outstanding.
//   - m_data/m_valid/m_last hold steady while m_valid & !m_ready.
// TESTING
//   1. RAM[0..3]=A0..A3, start addr=0 len=4, m_ready=1 -> rden cycles 1-4, m_valid cycles 3-6,
//      data A0..A3, m_last only on A3, done pulse cycle 7.
//   2. Same as 1 with m_ready=0 cycles 3-8 -> rden stops after 2 reads, no loss; A0..A3 in order, m_last A3.
//   3. start addr=2**ADDRS_WIDTH-2 len=4 -> rdaddrs 0x7FE,0x7FF,0x000,0x001; data matches RAM.
//   4. start len=0 -> no rden ever, done pulse next cycle, m_valid stays 0, busy stays 0.
//   5. start during busy (second burst) -> ignored; only first burst's words appear, one done pulse.
//   6. RESET_N low mid-burst after 2 words -> all outputs 0 immediately; after release idle, new
//      burst len=3 returns correct 3 words with no stale buffer contents.

Source files
------------

// File: rtl/sdp_ram_burst_reader_if.sv
// Bundles the SDP RAM read port, burst control and output stream of sdp_ram_burst_reader.
// The master modport is the reader itself; slave is the RAM/consumer/controller side.
interface sdp_ram_burst_reader_if #(
    parameter int ADDRS_WIDTH = 11,
    parameter int LEN_WIDTH   = 12
);
    logic                   start;
    logic [ADDRS_WIDTH-1:0] start_addrs;
    logic [LEN_WIDTH-1:0]   length;
    logic                   busy;
    logic                   done;
    logic                   rden;
    logic [ADDRS_WIDTH-1:0] rdaddrs;
    logic [31:0]            rddata;
    logic                   m_valid;
    logic                   m_ready;
    logic [31:0]            m_data;
    logic                   m_last;

    modport master (
        input  start, start_addrs, length, rddata, m_ready,
        output busy, done, rden, rdaddrs, m_valid, m_data, m_last
    );

    modport slave (
        output start, start_addrs, length, rddata, m_ready,
        input  busy, done, rden, rdaddrs, m_valid, m_data, m_last
    );
endinterface

// File: rtl/sdp_ram_burst_reader.sv
// Burst read master for a 1-cycle-latency SDP RAM, streaming words through a 2-entry
// buffer. Reads are only issued when the buffer is guaranteed room, so stalls never drop data.
module sdp_ram_burst_reader #(
    parameter int ADDRS_WIDTH = 11,
    parameter int LEN_WIDTH   = 12
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    sdp_ram_burst_reader_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [ADDRS_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic                   inflight_q, inflight_d;
    logic                   inflight_last_q, inflight_last_d;
    logic [1:0]             count_q, count_d;
    logic [31:0]            data0_q, data0_d, data1_q, data1_d;
    logic                   last0_q, last0_d, last1_q, last1_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   pop;
    logic                   rden_c;
    logic [2:0]             credit;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        data0_d         = data0_q;
        data1_d         = data1_q;
        last0_d         = last0_q;
        last1_d         = last1_q;

        pop    = (count_q != 2'd0) && bus.m_ready;
        // Occupancy the buffer will have once the read in flight lands, net of this cycle's pop.
        credit = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        rden_c = (state_q == S_READ) && (remaining_q != '0) && (credit < 3'd2);

        inflight_d      = rden_c;
        inflight_last_d = rden_c && (remaining_q == LEN_WIDTH'(1));

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.length != '0) begin
                        state_d     = S_READ;
                        addr_d      = bus.start_addrs;
                        remaining_d = bus.length;
                        busy_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (rden_c) begin
                    addr_d      = addr_q + ADDRS_WIDTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && last0_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Head is always entry 0; a pop shifts entry 1 down before any push lands.
        if (pop) begin
            data0_d = data1_q;
            last0_d = last1_q;
        end
        if (inflight_q) begin
            if (count_q == {1'b0, pop}) begin
                data0_d = bus.rddata;
                last0_d = inflight_last_q;
            end else begin
                data1_d = bus.rddata;
                last1_d = inflight_last_q;
            end
        end
        count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= 2'd0;
            data0_q         <= '0;
            data1_q         <= '0;
            last0_q         <= 1'b0;
            last1_q         <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            count_q         <= count_d;
            data0_q         <= data0_d;
            data1_q         <= data1_d;
            last0_q         <= last0_d;
            last1_q         <= last1_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rden    = rden_c;
    assign bus.rdaddrs = addr_q;
    assign bus.m_valid = (count_q != 2'd0);
    assign bus.m_data  = data0_q;
    assign bus.m_last  = last0_q && (count_q != 2'd0);
endmodule

// File: tb/tb_sdp_ram_burst_reader.sv
// Directed bench for sdp_ram_burst_reader with a 1-cycle read-latency RAM model.
// RAM word at address a holds 32'hD000_0000 | a.
module tb_sdp_ram_burst_reader;
    localparam int AW = 11;
    localparam int LW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdp_ram_burst_reader_if #(.ADDRS_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    sdp_ram_burst_reader #(.ADDRS_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus.master)
    );

    logic [31:0] ram [0:2047];
    always @(posedge clk) if (bus.rden) bus.rddata <= ram[bus.rdaddrs];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]   got_data [$];
    logic          got_last [$];
    int            pop_cyc  [$];
    int            rden_cyc [$];
    logic [AW-1:0] rd_addr  [$];
    int            done_cnt, done_cyc, busy_cnt, valid_cnt, hold_bad;
    logic          busy_at_done, busy_c1;

    // Start a burst at cycle 0 and record activity for cycles 1..ncyc (sampled on negedge).
    task automatic run_burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input int ncyc,
                             input int st_lo, input int st_hi,
                             input int re_cyc, input logic [AW-1:0] re_a, input logic [LW-1:0] re_l);
        logic        pv;
        logic [31:0] pd;
        got_data.delete(); got_last.delete(); pop_cyc.delete(); rden_cyc.delete(); rd_addr.delete();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; valid_cnt = 0; hold_bad = 0;
        busy_at_done = 1'bx; busy_c1 = 1'bx; pv = 1'b0; pd = '0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.start_addrs = a; bus.length = l; bus.m_ready = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            bus.start = (c == re_cyc);
            if (c == re_cyc) begin bus.start_addrs = re_a; bus.length = re_l; end
            bus.m_ready = !(c >= st_lo && c <= st_hi);
            @(negedge clk);
            if (bus.rden) begin rden_cyc.push_back(c); rd_addr.push_back(bus.rdaddrs); end
            if (bus.m_valid && bus.m_ready) begin
                got_data.push_back(bus.m_data); got_last.push_back(bus.m_last); pop_cyc.push_back(c);
            end
            if (bus.m_valid && !bus.m_ready) begin
                if (pv && bus.m_data !== pd) hold_bad++;
                pv = 1'b1; pd = bus.m_data;
            end else pv = 1'b0;
            if (bus.done) begin done_cnt++; done_cyc = c; busy_at_done = bus.busy; end
            if (bus.busy) busy_cnt++;
            if (bus.m_valid) valid_cnt++;
            if (c == 1) busy_c1 = bus.busy;
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.m_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)    begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_cmp++; if (bus.rden !== 1'b0)    begin n_bad++; $display("FAIL reset_rden: got %b expected 0", bus.rden); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
        n_cmp++; if (bus.m_data !== 32'h0) begin n_bad++; $display("FAIL reset_m_data: got %h expected 0", bus.m_data); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic_burst();
        run_burst(11'h000, 12'd4, 10, 0, -1, -1, '0, '0);
        n_cmp++; if (busy_c1 !== 1'b1) begin n_bad++; $display("FAIL basic_busy_c1: got %b expected 1", busy_c1); end
        n_cmp++; if (rden_cyc.size() != 4) begin n_bad++; $display("FAIL basic_rden_count: got %0d expected 4", rden_cyc.size()); end
        else for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rden_cyc[i] != i + 1) begin n_bad++; $display("FAIL basic_rden_cyc[%0d]: got %0d expected %0d", i, rden_cyc[i], i + 1); end
            n_cmp++; if (rd_addr[i] !== AW'(i)) begin n_bad++; $display("FAIL basic_rdaddrs[%0d]: got %h expected %h", i, rd_addr[i], i); end
        end
        n_cmp++; if (got_data.size() != 4) begin n_bad++; $display("FAIL basic_word_count: got %0d expected 4", got_data.size()); end
        else for (int i = 0; i < 4; i++) begin
            n_cmp++; if (pop_cyc[i] != i + 3) begin n_bad++; $display("FAIL basic_valid_cyc[%0d]: got %0d expected %0d", i, pop_cyc[i], i + 3); end
            n_cmp++; if (got_data[i] !== (32'hD000_0000 | 32'(i))) begin n_bad++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got_data[i], 32'hD000_0000 | 32'(i)); end
            n_cmp++; if (got_last[i] !== (i == 3)) begin n_bad++; $display("FAIL basic_last[%0d]: got %b expected %b", i, got_last[i], i == 3); end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_cyc != 7) begin n_bad++; $display("FAIL basic_done_cyc: got %0d expected 7", done_cyc); end
        n_cmp++; if (busy_at_done !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done); end
    endtask

    task automatic test_stall();
        int exp_rden [4];
        exp_rden = '{1, 2, 9, 10};
        run_burst(11'h000, 12'd4, 16, 3, 8, -1, '0, '0);
        n_cmp++; if (rden_cyc.size() != 4) begin n_bad++; $display("FAIL stall_rden_count: got %0d expected 4", rden_cyc.size()); end
        else for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rden_cyc[i] != exp_rden[i]) begin n_bad++; $display("FAIL stall_rden_cyc[%0d]: got %0d expected %0d", i, rden_cyc[i], exp_rden[i]); end
        end
        n_cmp++; if (got_data.size() != 4) begin n_bad++; $display("FAIL stall_word_count: got %0d expected 4", got_data.size()); end
        else for (int i = 0; i < 4; i++) begin
            n_cmp++; if (pop_cyc[i] != i + 9) begin n_bad++; $display("FAIL stall_pop_cyc[%0d]: got %0d expected %0d", i, pop_cyc[i], i + 9); end
            n_cmp++; if (got_data[i] !== (32'hD000_0000 | 32'(i))) begin n_bad++; $display("FAIL stall_data[%0d]: got %h expected %h", i, got_data[i], 32'hD000_0000 | 32'(i)); end
            n_cmp++; if (got_last[i] !== (i == 3)) begin n_bad++; $display("FAIL stall_last[%0d]: got %b expected %b", i, got_last[i], i == 3); end
        end
        n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL stall_hold: got %0d changes expected 0", hold_bad); end
        n_cmp++; if (done_cyc != 13) begin n_bad++; $display("FAIL stall_done_cyc: got %0d expected 13", done_cyc); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        exp_a = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        run_burst(11'h7FE, 12'd4, 10, 0, -1, -1, '0, '0);
        n_cmp++; if (rd_addr.size() != 4) begin n_bad++; $display("FAIL wrap_rden_count: got %0d expected 4", rd_addr.size()); end
        else for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rd_addr[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_rdaddrs[%0d]: got %h expected %h", i, rd_addr[i], exp_a[i]); end
        end
        n_cmp++; if (got_data.size() != 4) begin n_bad++; $display("FAIL wrap_word_count: got %0d expected 4", got_data.size()); end
        else for (int i = 0; i < 4; i++) begin
            n_cmp++; if (got_data[i] !== (32'hD000_0000 | 32'(exp_a[i]))) begin n_bad++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, got_data[i], 32'hD000_0000 | 32'(exp_a[i])); end
        end
    endtask

    task automatic test_zero_length();
        run_burst(11'h020, 12'd0, 5, 0, -1, -1, '0, '0);
        n_cmp++; if (rden_cyc.size() != 0) begin n_bad++; $display("FAIL zero_rden: got %0d reads expected 0", rden_cyc.size()); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_cyc != 1) begin n_bad++; $display("FAIL zero_done_cyc: got %0d expected 1", done_cyc); end
        n_cmp++; if (valid_cnt != 0) begin n_bad++; $display("FAIL zero_m_valid: got %0d cycles expected 0", valid_cnt); end
        n_cmp++; if (busy_cnt != 0) begin n_bad++; $display("FAIL zero_busy: got %0d cycles expected 0", busy_cnt); end
    endtask

    task automatic test_start_while_busy();
        run_burst(11'h004, 12'd2, 12, 0, -1, 2, 11'h008, 12'd3);
        n_cmp++; if (rden_cyc.size() != 2) begin n_bad++; $display("FAIL busy_start_rden_count: got %0d expected 2", rden_cyc.size()); end
        n_cmp++; if (got_data.size() != 2) begin n_bad++; $display("FAIL busy_start_word_count: got %0d expected 2", got_data.size()); end
        else for (int i = 0; i < 2; i++) begin
            n_cmp++; if (got_data[i] !== (32'hD000_0004 + 32'(i))) begin n_bad++; $display("FAIL busy_start_data[%0d]: got %h expected %h", i, got_data[i], 32'hD000_0004 + 32'(i)); end
            n_cmp++; if (got_last[i] !== (i == 1)) begin n_bad++; $display("FAIL busy_start_last[%0d]: got %b expected %b", i, got_last[i], i == 1); end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        run_burst(11'h000, 12'd4, 4, 0, -1, -1, '0, '0);
        n_cmp++; if (got_data.size() != 2) begin n_bad++; $display("FAIL midrst_words_before: got %0d expected 2", got_data.size()); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0)     begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)     begin n_bad++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
        n_cmp++; if (bus.rden !== 1'b0)     begin n_bad++; $display("FAIL midrst_rden: got %b expected 0", bus.rden); end
        n_cmp++; if (bus.m_valid !== 1'b0)  begin n_bad++; $display("FAIL midrst_m_valid: got %b expected 0", bus.m_valid); end
        n_cmp++; if (bus.m_last !== 1'b0)   begin n_bad++; $display("FAIL midrst_m_last: got %b expected 0", bus.m_last); end
        n_cmp++; if (bus.rdaddrs !== '0)    begin n_bad++; $display("FAIL midrst_rdaddrs: got %h expected 0", bus.rdaddrs); end
        n_cmp++; if (bus.m_data !== 32'h0)  begin n_bad++; $display("FAIL midrst_m_data: got %h expected 0", bus.m_data); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.rden !== 1'b0 || bus.m_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_bad++; $display("FAIL midrst_idle[%0d]: got rden=%b m_valid=%b busy=%b expected all 0", c, bus.rden, bus.m_valid, bus.busy);
            end
        end
        run_burst(11'h010, 12'd3, 10, 0, -1, -1, '0, '0);
        n_cmp++; if (got_data.size() != 3) begin n_bad++; $display("FAIL midrst_word_count: got %0d expected 3", got_data.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++; if (got_data[i] !== (32'hD000_0010 + 32'(i))) begin n_bad++; $display("FAIL midrst_data[%0d]: got %h expected %h", i, got_data[i], 32'hD000_0010 + 32'(i)); end
            n_cmp++; if (got_last[i] !== (i == 2)) begin n_bad++; $display("FAIL midrst_last[%0d]: got %b expected %b", i, got_last[i], i == 2); end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL midrst_done_count: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 32'hD000_0000 | 32'(i);
        bus.start = 1'b0; bus.start_addrs = '0; bus.length = '0; bus.m_ready = 1'b1;
        test_reset();
        test_basic_burst();
        test_stall();
        test_wrap();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
